mem_stage_ctrl: RTL and testbench

- Memory-stage controller; sits between the execute/memory pipe register and mwpipe.
- Issues data-memory reads and writes over a req/ack handshake that can take several cycles.
- Stalls upstream while an access is outstanding.
- Presents the registered M-stage bundle (regw_M, regmem_M, regScr_M, ALUrslt_M, rdata_M) that mwpipe samples every cycle.

---
 rtl/mem_stage_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues data-memory accesses over a req/ack handshake,
// stalls upstream while one is outstanding and presents the registered M-stage bundle.
module mem_stage_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_W    = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_E,
  input  logic              regw_E,
  input  logic              regmem_E,
  input  logic              memw_E,
  input  logic [REG_W-1:0]  regScr_E,
  input  logic [DATA_W-1:0] ALUrslt_E,
  input  logic [DATA_W-1:0] wdata_E,
  output logic              stall_E,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              regw_M,
  output logic              regmem_M,
  output logic [REG_W-1:0]  regScr_M,
  output logic [DATA_W-1:0] ALUrslt_M,
  output logic [DATA_W-1:0] rdata_M,
  output logic              err_M
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntLim = CntW'(MAX_WAIT - 1);

  typedef enum logic {StIdle, StWait} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                lat_regw_q, lat_regw_d;
  logic                lat_load_q, lat_load_d;
  logic [REG_W-1:0]    lat_scr_q, lat_scr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                regw_q, regw_d;
  logic                regmem_q, regmem_d;
  logic [REG_W-1:0]    scr_q, scr_d;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_regw_d = lat_regw_q;
    lat_load_d = lat_load_q;
    lat_scr_d  = lat_scr_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    regw_d     = 1'b0;
    regmem_d   = 1'b0;
    scr_d      = '0;
    alu_d      = '0;
    rdata_d    = '0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid_E && (regmem_E || memw_E)) begin
          state_d    = StWait;
          cnt_d      = '0;
          lat_regw_d = regw_E;
          lat_load_d = regmem_E;
          lat_scr_d  = regScr_E;
          // Load+store together is illegal; it is issued as a load.
          we_d       = memw_E & ~regmem_E;
          addr_d     = ALUrslt_E;
          wdata_d    = wdata_E;
        end else if (valid_E) begin
          regw_d = regw_E;
          scr_d  = regScr_E;
          alu_d  = ALUrslt_E;
        end
      end
      StWait: begin
        if (mem_ack) begin
          state_d  = StIdle;
          regw_d   = lat_regw_q;
          regmem_d = lat_load_q;
          scr_d    = lat_scr_q;
          alu_d    = addr_q;
          rdata_d  = lat_load_q ? mem_rdata : '0;
          we_d     = 1'b0;
          addr_d   = '0;
          wdata_d  = '0;
        end else if (cnt_q == CntLim) begin
          state_d = StIdle;
          err_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lat_regw_q <= 1'b0;
      lat_load_q <= 1'b0;
      lat_scr_q  <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      regw_q     <= 1'b0;
      regmem_q   <= 1'b0;
      scr_q      <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_regw_q <= lat_regw_d;
      lat_load_q <= lat_load_d;
      lat_scr_q  <= lat_scr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      regw_q     <= regw_d;
      regmem_q   <= regmem_d;
      scr_q      <= scr_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign stall_E   = (state_q == StWait);
  assign mem_req   = (state_q == StWait);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign regw_M    = regw_q;
  assign regmem_M  = regmem_q;
  assign regScr_M  = scr_q;
  assign ALUrslt_M = alu_q;
  assign rdata_M   = rdata_q;
  assign err_M     = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios then randomized traffic, all checked
// against a transaction-level model of the memory stage.
module tb_mem_stage_ctrl;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_E, regw_E, regmem_E, memw_E, mem_ack;
  logic [RW-1:0] regScr_E;
  logic [DW-1:0] ALUrslt_E, wdata_E, mem_rdata;
  logic          stall_E, mem_req, mem_we, regw_M, regmem_M, err_M;
  logic [DW-1:0] mem_addr, mem_wdata, ALUrslt_M, rdata_M;
  logic [RW-1:0] regScr_M;

  mem_stage_ctrl #(.DATA_W(DW), .REG_W(RW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .valid_E(valid_E), .regw_E(regw_E), .regmem_E(regmem_E),
    .memw_E(memw_E), .regScr_E(regScr_E), .ALUrslt_E(ALUrslt_E), .wdata_E(wdata_E),
    .stall_E(stall_E), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .regw_M(regw_M),
    .regmem_M(regmem_M), .regScr_M(regScr_M), .ALUrslt_M(ALUrslt_M), .rdata_M(rdata_M),
    .err_M(err_M)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: one outstanding access plus the bundle the M stage should show.
  bit            m_busy;
  int            m_waits;
  bit            m_regw, m_load, m_we;
  logic [RW-1:0] m_scr;
  logic [DW-1:0] m_addr, m_wdata;
  bit            e_regw, e_regmem, e_err;
  logic [RW-1:0] e_scr;
  logic [DW-1:0] e_alu, e_rdata;

  task automatic bubble();
    e_regw = 0; e_regmem = 0; e_scr = '0; e_alu = '0; e_rdata = '0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_waits = 0; m_regw = 0; m_load = 0; m_we = 0;
    m_scr = '0; m_addr = '0; m_wdata = '0; e_err = 0;
    bubble();
  endtask

  task automatic model_edge();
    if (!rst) begin
      model_reset();
      return;
    end
    e_err = 0;
    bubble();
    if (!m_busy) begin
      if (valid_E && (regmem_E || memw_E)) begin
        m_busy = 1; m_waits = 0;
        m_regw = regw_E; m_load = regmem_E; m_we = memw_E && !regmem_E;
        m_scr = regScr_E; m_addr = ALUrslt_E; m_wdata = wdata_E;
      end else if (valid_E) begin
        e_regw = regw_E; e_scr = regScr_E; e_alu = ALUrslt_E;
      end
    end else if (mem_ack) begin
      m_busy = 0;
      e_regw = m_regw; e_regmem = m_load; e_scr = m_scr; e_alu = m_addr;
      e_rdata = m_load ? mem_rdata : '0;
    end else begin
      m_waits++;
      if (m_waits == MW) begin
        m_busy = 0;
        e_err = 1;
      end
    end
  endtask

  task automatic check_all();
    check("stall_E", 32'(stall_E), 32'(m_busy));
    check("mem_req", 32'(mem_req), 32'(m_busy));
    if (m_busy) begin
      check("mem_we", 32'(mem_we), 32'(m_we));
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
    end
    check("regw_M", 32'(regw_M), 32'(e_regw));
    check("regmem_M", 32'(regmem_M), 32'(e_regmem));
    check("regScr_M", 32'(regScr_M), 32'(e_scr));
    check("ALUrslt_M", ALUrslt_M, e_alu);
    check("rdata_M", rdata_M, e_rdata);
    check("err_M", 32'(err_M), 32'(e_err));
  endtask

  task automatic check_mem_zero();
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_op(input bit v, input bit rw, input bit rm, input bit mw,
                        input logic [RW-1:0] scr, input logic [DW-1:0] alu,
                        input logic [DW-1:0] wd);
    valid_E = v; regw_E = rw; regmem_E = rm; memw_E = mw;
    regScr_E = scr; ALUrslt_E = alu; wdata_E = wd;
  endtask

  task automatic randomize_inputs(input int ack_pct);
    set_op(($urandom % 100) < 70, 1'($urandom), 1'($urandom), 1'($urandom),
           RW'($urandom), $urandom, $urandom);
    mem_ack   = ($urandom % 100) < ack_pct;
    mem_rdata = $urandom;
  endtask

  int pcts[6] = '{50, 0, 100, 20, 0, 35};

  initial begin
    model_reset();
    // Reset held across edges with random inputs.
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs(50);
      cycle();
      check_mem_zero();
    end
    #3 rst = 1;
    mem_ack = 0;

    // ALU ops back to back.
    set_op(1, 1, 0, 0, 4'b0011, 32'h0000FFFF, 32'h0);
    cycle();
    check("alu_scr", 32'(regScr_M), 32'd3);
    set_op(1, 1, 0, 0, 4'b0100, 32'h00000042, 32'h0);
    cycle();
    check("alu2_scr", 32'(regScr_M), 32'd4);

    // Load, ack on third WAIT edge; next op held until IDLE.
    set_op(1, 1, 1, 0, 4'b0100, 32'h10, 32'h0);
    cycle();
    set_op(1, 1, 0, 0, 4'd7, 32'h77, 32'h0);
    cycle();
    cycle();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    cycle();
    check("load_rdata", rdata_M, 32'hDEADBEEF);
    mem_ack = 0;
    cycle();
    check("after_load_scr", 32'(regScr_M), 32'd7);

    // Store, ack on first WAIT edge.
    set_op(1, 0, 0, 1, 4'd5, 32'h20, 32'h12345678);
    cycle();
    check("store_wdata", mem_wdata, 32'h12345678);
    set_op(0, 0, 0, 0, 4'd0, 32'h0, 32'h0);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    cycle();
    check("store_rdata", rdata_M, 32'd0);
    mem_ack = 0;

    // Timeout then late ack in IDLE.
    set_op(1, 1, 1, 0, 4'd9, 32'h30, 32'h0);
    cycle();
    set_op(0, 0, 0, 0, 4'd0, 32'h0, 32'h0);
    for (int i = 0; i < MW; i++) cycle();
    check("timeout_err", 32'(err_M), 32'd1);
    cycle();
    mem_ack = 1;
    cycle();
    mem_ack = 0;
    cycle();

    // Reset during WAIT drops the request immediately.
    set_op(1, 1, 1, 0, 4'd6, 32'h40, 32'h0);
    cycle();
    set_op(1, 1, 0, 0, 4'd2, 32'h55, 32'h0);
    cycle();
    #2 rst = 0;
    #1;
    model_reset();
    check_all();
    check_mem_zero();
    cycle();
    #3 rst = 1;
    cycle();
    check("post_rst_scr", 32'(regScr_M), 32'd2);

    // Randomized traffic with varying ack likelihood.
    foreach (pcts[b]) begin
      for (int i = 0; i < 100; i++) begin
        randomize_inputs(pcts[b]);
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
